// File: rtl/dmem_responder.sv
// Single-port data memory responder for the memory stage: big-endian 32-bit words,
// byte/word access, IDLE/WAIT/DONE handshake. Define DMEM_WAIT_EN to enable WAIT_CYCLES wait states.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic        mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stall_req_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
`ifdef DMEM_WAIT_EN
    localparam int EFF_WAIT = WAIT_CYCLES;
`else
    localparam int EFF_WAIT = 0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    we_reg;
    logic                    sel_reg;
    logic [DEPTH_LOG2+1:0]   addr_reg;
    logic [31:0]             data_reg;
    logic [31:0]             rdata_reg;
    logic                    ack_reg;
    logic                    err_reg;

    // Access attributes: taken live from the inputs in IDLE, from the latched copy afterwards.
    logic                    acc_we;
    logic                    acc_mis;
    logic [1:0]              acc_off;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [DEPTH_LOG2-1:0]   wr_idx;
    logic [31:0]             rd_word;
    logic [3:0]              lane_we;
    logic [7:0]              lane_wdata [4];
    logic                    mem_write;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^mem_addr_i[31:DEPTH_LOG2+2];

    always_comb begin
        acc_we  = we_reg;
        acc_off = addr_reg[1:0];
        acc_mis = sel_reg && (addr_reg[1:0] != 2'b00);
        rd_idx  = addr_reg[DEPTH_LOG2+1:2];
        if (state_reg == IDLE) begin
            acc_we  = mem_we_i;
            acc_off = mem_addr_i[1:0];
            acc_mis = mem_sel_i && (mem_addr_i[1:0] != 2'b00);
            rd_idx  = mem_addr_i[DEPTH_LOG2+1:2];
        end
    end

    // The write commits on the edge leaving DONE, so a reset seen in DONE cancels it.
    assign mem_write = (state_reg == DONE) && !rst && we_reg && !err_reg;
    assign wr_idx    = addr_reg[DEPTH_LOG2+1:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            assign lane_we[gi]    = mem_write && (sel_reg || (addr_reg[1:0] == 2'(gi)));
            assign lane_wdata[gi] = sel_reg ? data_reg[31-8*gi -: 8] : data_reg[7:0];
            assign rd_word[31-8*gi -: 8] = lane_mem[rd_idx];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[wr_idx] <= lane_wdata[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            rdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_ce_i) begin
                        we_reg   <= mem_we_i;
                        sel_reg  <= mem_sel_i;
                        addr_reg <= mem_addr_i[DEPTH_LOG2+1:0];
                        data_reg <= mem_data_i;
                        if (EFF_WAIT > 0) begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            state_reg <= DONE;
                            ack_reg   <= 1'b1;
                            err_reg   <= acc_mis;
                            if (!acc_we && !acc_mis) begin
                                rdata_reg <= rd_word << {acc_off, 3'b000};
                            end
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= DONE;
                        ack_reg   <= 1'b1;
                        err_reg   <= acc_mis;
                        if (!acc_we && !acc_mis) begin
                            rdata_reg <= rd_word << {acc_off, 3'b000};
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign stall_req_o = !rst && (((state_reg == IDLE) && mem_ce_i) || (state_reg == WAIT));
    assign mem_data_o  = rdata_reg;
    assign ack_o       = ack_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array memory model.
module tb_dmem_responder;

    localparam int DL    = 6;
    localparam int DEPTH = 1 << DL;
    localparam int WC    = 2;
`ifdef DMEM_WAIT_EN
    localparam int EXP_LAT = WC + 2;
`else
    localparam int EXP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0, we = 1'b0, sel = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        stall, ack, err;

    int checks = 0;
    int failures = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rd = '0;

    dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_sel_i(sel),
        .mem_addr_i(addr), .mem_data_i(wdata), .mem_data_o(rdata),
        .stall_req_o(stall), .ack_o(ack), .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference behaviour: returns whether the access should flag err and updates the model.
    function automatic bit model(input bit m_we, input bit m_sel, input logic [31:0] m_addr,
                                 input logic [31:0] m_data);
        int idx = int'((m_addr >> 2) % DEPTH);
        int off = int'(m_addr % 4);
        logic [31:0] w;
        if (m_sel && off != 0) return 1'b1;
        if (m_we) begin
            if (m_sel) ref_mem[idx] = m_data;
            else begin
                w = ref_mem[idx];
                w[31-8*off -: 8] = m_data[7:0];
                ref_mem[idx] = w;
            end
        end else begin
            exp_rd = ref_mem[idx] << (8 * off);
        end
        return 1'b0;
    endfunction

    // Runs one access, scrambling the request inputs while it is in flight.
    task automatic do_access(input bit a_we, input bit a_sel, input logic [31:0] a_addr,
                             input logic [31:0] a_data, output int lat, output bit o_err,
                             output logic [31:0] o_rd, output bit stall_bad);
        @(posedge clk); #1;
        ce = 1'b1; we = a_we; sel = a_sel; addr = a_addr; wdata = a_data;
        #1;
        stall_bad = (stall !== 1'b1) || (ack !== 1'b0);
        lat = -1; o_err = 1'b0; o_rd = 'x;
        for (int c = 2; c <= 50; c++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                lat = c; o_err = err; o_rd = rdata;
                if (stall !== 1'b0) stall_bad = 1'b1;
                break;
            end
            if (stall !== 1'b1) stall_bad = 1'b1;
            ce = 1'(($urandom % 2)); we = 1'(($urandom % 2)); sel = 1'(($urandom % 2));
            addr = $urandom; wdata = $urandom;
        end
        ce = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; ce = 1'b1; we = 1'b0; sel = 1'b1; addr = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset: stall=%b ack=%b err=%b data=%h, required 0 0 0 00000000",
                     stall, ack, err, rdata);
        end
        ce = 1'b0; rst = 1'b0;
        exp_rd = '0;
    endtask

    task automatic test_fill;
        int lat; bit e, sb; logic [31:0] rd, d;
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            void'(model(1'b1, 1'b1, 32'(i * 4), d));
            do_access(1'b1, 1'b1, 32'(i * 4), d, lat, e, rd, sb);
            if (lat != EXP_LAT || e !== 1'b0 || sb) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL fill: %0d word writes with wrong latency/err/stall, required 0", bad);
        end
    endtask

    task automatic test_directed;
        int lat; bit e, sb; logic [31:0] rd;
        void'(model(1'b1, 1'b1, 32'h10, 32'h12345678));
        do_access(1'b1, 1'b1, 32'h10, 32'h12345678, lat, e, rd, sb);
        checks++;
        if (lat != EXP_LAT || sb) begin
            failures++; $display("FAIL sw_timing: ack at cycle %0d stall_bad=%b, required %0d 0", lat, sb, EXP_LAT);
        end
        void'(model(1'b0, 1'b1, 32'h10, 32'h0));
        do_access(1'b0, 1'b1, 32'h10, 32'h0, lat, e, rd, sb);
        checks++;
        if (lat != EXP_LAT || sb || rd !== 32'h12345678) begin
            failures++; $display("FAIL lw: lat=%0d stall_bad=%b data=%h, required %0d 0 12345678", lat, sb, rd, EXP_LAT);
        end
        void'(model(1'b1, 1'b0, 32'h11, 32'hABABABAB));
        do_access(1'b1, 1'b0, 32'h11, 32'hABABABAB, lat, e, rd, sb);
        checks++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin
            failures++; $display("FAIL sb_hold: data=%h err=%b, required 12345678 0", rd, e);
        end
        void'(model(1'b0, 1'b1, 32'h10, 32'h0));
        do_access(1'b0, 1'b1, 32'h10, 32'h0, lat, e, rd, sb);
        checks++;
        if (rd !== 32'h12AB5678) begin
            failures++; $display("FAIL sb_readback: data=%h, required 12ab5678", rd);
        end
        void'(model(1'b1, 1'b1, 32'h10, 32'h12345678));
        do_access(1'b1, 1'b1, 32'h10, 32'h12345678, lat, e, rd, sb);
        void'(model(1'b0, 1'b0, 32'h12, 32'h0));
        do_access(1'b0, 1'b0, 32'h12, 32'h0, lat, e, rd, sb);
        checks++;
        if (rd !== 32'h56780000 || e !== 1'b0) begin
            failures++; $display("FAIL lb: data=%h err=%b, required 56780000 0", rd, e);
        end
        void'(model(1'b1, 1'b1, 32'h13, 32'hDEADBEEF));
        do_access(1'b1, 1'b1, 32'h13, 32'hDEADBEEF, lat, e, rd, sb);
        checks++;
        if (e !== 1'b1 || lat != EXP_LAT || rd !== 32'h56780000) begin
            failures++; $display("FAIL misaligned_sw: err=%b lat=%0d data=%h, required 1 %0d 56780000", e, lat, rd, EXP_LAT);
        end
        // Aliased address: one memory-size above 0x10 maps onto the same word.
        void'(model(1'b0, 1'b1, 32'h10 + 32'(DEPTH * 4), 32'h0));
        do_access(1'b0, 1'b1, 32'h10 + 32'(DEPTH * 4), 32'h0, lat, e, rd, sb);
        checks++;
        if (rd !== 32'h12345678) begin
            failures++; $display("FAIL wrap_read: data=%h, required 12345678", rd);
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 6; i++) begin
            ce = 1'b0; we = 1'(($urandom % 2)); sel = 1'(($urandom % 2));
            addr = $urandom; wdata = $urandom;
            @(posedge clk); #1;
            checks++;
            if (stall !== 1'b0 || ack !== 1'b0 || err !== 1'b0 || rdata !== exp_rd) begin
                failures++;
                $display("FAIL idle: stall=%b ack=%b err=%b data=%h, required 0 0 0 %h",
                         stall, ack, err, rdata, exp_rd);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat; bit e, sb; logic [31:0] rd;
        logic [31:0] old = ref_mem[5];
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b1; sel = 1'b1; addr = 32'h14; wdata = ~old;
        @(posedge clk); #1;
        ce = 1'b0; rst = 1'b1; #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++; $display("FAIL stall_in_reset: stall=%b, required 0", stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd = '0;
        checks++;
        if (stall !== 1'b0 || ack !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: stall=%b ack=%b err=%b data=%h, required 0 0 0 00000000", stall, ack, err, rdata);
        end
        void'(model(1'b0, 1'b1, 32'h14, 32'h0));
        do_access(1'b0, 1'b1, 32'h14, 32'h0, lat, e, rd, sb);
        checks++;
        if (rd !== old || lat != EXP_LAT) begin
            failures++; $display("FAIL reset_mid_mem: data=%h lat=%0d, required %h %0d", rd, lat, old, EXP_LAT);
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit e, sb, ee; logic [31:0] rd, a, d; bit rw, rs;
        for (int i = 0; i < 200; i++) begin
            rw = 1'(($urandom % 2)); rs = 1'(($urandom % 2));
            a = $urandom;
            if (($urandom % 4) != 0 && rs) a[1:0] = 2'b00;
            d = $urandom;
            if (!rs) d = {4{d[7:0]}};
            ee = model(rw, rs, a, d);
            do_access(rw, rs, a, d, lat, e, rd, sb);
            checks++;
            if (lat != EXP_LAT || sb || e !== ee || rd !== exp_rd) begin
                failures++;
                $display("FAIL random[%0d] we=%b sel=%b addr=%h: lat=%0d stall_bad=%b err=%b data=%h, required %0d 0 %b %h",
                         i, rw, rs, a, lat, sb, e, rd, EXP_LAT, ee, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_idle();
        test_reset_mid();
        test_back_to_back();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
